// File: rtl/step_shaper.sv
// step_shaper: turns raw motion-engine step/dir levels into driver-legal pulses.
// Define STEP_SHAPER_BOTH_EDGES_EN to count both step_in edges as requests.
module step_shaper #(
    parameter int MOTORS    = 3,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [MOTORS-1:0]    step_in,
    input  logic [MOTORS-1:0]    dir_in,
    input  logic [CNT_WIDTH-1:0] t_setup,
    input  logic [CNT_WIDTH-1:0] t_high,
    input  logic [CNT_WIDTH-1:0] t_low,
    input  logic                 ovr_clear,
    output logic [MOTORS-1:0]    m_step,
    output logic [MOTORS-1:0]    m_dir,
    output logic [MOTORS-1:0]    overrun,
    output logic [MOTORS-1:0]    busy
);
    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

    localparam logic [CNT_WIDTH-1:0] ONE = 1;

    logic [MOTORS-1:0]    prev_step;
    logic [MOTORS-1:0]    req;
    logic [CNT_WIDTH-1:0] ld_setup;
    logic [CNT_WIDTH-1:0] ld_high;
    logic [CNT_WIDTH-1:0] ld_low;

`ifdef STEP_SHAPER_BOTH_EDGES_EN
    assign req = step_in ^ prev_step;
`else
    assign req = step_in & ~prev_step;
`endif

    // A zero field still means one clock, so load max(t,1)-1.
    assign ld_setup = (t_setup == '0) ? '0 : t_setup - ONE;
    assign ld_high  = (t_high == '0)  ? '0 : t_high - ONE;
    assign ld_low   = (t_low == '0)   ? '0 : t_low - ONE;

    always_ff @(posedge clk) begin
        prev_step <= step_in;
    end

    for (genvar i = 0; i < MOTORS; i++) begin : g_ch
        state_t               state;
        logic [CNT_WIDTH-1:0] timer;
        logic                 pend;
        logic                 pend_dir;
        logic                 step_r;
        logic                 dir_r;
        logic                 ovr_r;
        logic                 start;
        logic                 src_dir;
        logic                 drop;

        always_comb begin
            start   = (state == IDLE) & (pend | req[i]);
            src_dir = pend ? pend_dir : dir_in[i];
            drop    = req[i] & pend & ~start;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state    <= IDLE;
                timer    <= '0;
                pend     <= 1'b0;
                pend_dir <= 1'b0;
                step_r   <= 1'b0;
                dir_r    <= 1'b0;
                ovr_r    <= 1'b0;
            end else begin
                // Leaving IDLE frees the slot for a same-cycle request.
                if (start) begin
                    pend <= pend & req[i];
                end else if (req[i]) begin
                    pend <= 1'b1;
                end
                if (req[i] & ~drop) begin
                    pend_dir <= dir_in[i];
                end

                if (drop) begin
                    ovr_r <= 1'b1;
                end else if (ovr_clear) begin
                    ovr_r <= 1'b0;
                end

                unique case (state)
                    IDLE: begin
                        if (start) begin
                            if (src_dir == dir_r) begin
                                state  <= HIGH;
                                step_r <= 1'b1;
                                timer  <= ld_high;
                            end else begin
                                state <= SETUP;
                                dir_r <= src_dir;
                                timer <= ld_setup;
                            end
                        end
                    end
                    SETUP: begin
                        if (timer == '0) begin
                            state  <= HIGH;
                            step_r <= 1'b1;
                            timer  <= ld_high;
                        end else begin
                            timer <= timer - ONE;
                        end
                    end
                    HIGH: begin
                        if (timer == '0) begin
                            state  <= LOW;
                            step_r <= 1'b0;
                            timer  <= ld_low;
                        end else begin
                            timer <= timer - ONE;
                        end
                    end
                    LOW: begin
                        if (timer == '0) begin
                            state <= IDLE;
                        end else begin
                            timer <= timer - ONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign m_step[i]  = step_r;
        assign m_dir[i]   = dir_r;
        assign overrun[i] = ovr_r;
        assign busy[i]    = (state != IDLE) | pend;
    end

endmodule

// File: tb/tb_step_shaper.sv
// tb_step_shaper: timeline-model bench for step_shaper, directed
// cases from the test plan followed by randomized step/dir traffic.
module tb_step_shaper;
    localparam int M = 3;
    localparam int W = 8;
`ifdef STEP_SHAPER_BOTH_EDGES_EN
    localparam bit BOTH = 1'b1;
`else
    localparam bit BOTH = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [M-1:0] step_in = '0;
    logic [M-1:0] dir_in = '0;
    logic [W-1:0] t_setup = '0;
    logic [W-1:0] t_high = '0;
    logic [W-1:0] t_low = '0;
    logic         ovr_clear = 1'b0;
    logic [M-1:0] m_step;
    logic [M-1:0] m_dir;
    logic [M-1:0] overrun;
    logic [M-1:0] busy;

    always #5 clk = ~clk;

    step_shaper #(.MOTORS(M), .CNT_WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .step_in(step_in), .dir_in(dir_in),
        .t_setup(t_setup), .t_high(t_high), .t_low(t_low),
        .ovr_clear(ovr_clear),
        .m_step(m_step), .m_dir(m_dir),
        .overrun(overrun), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int mx1(input logic [W-1:0] t);
        return (t == '0) ? 1 : int'(t);
    endfunction

    // Timeline model: each pulse is a set of edge indices.
    int idle_at[M];
    int hs[M];
    int he[M];
    bit mdir[M];
    bit pend[M];
    bit pdir[M];
    bit ovr[M];
    bit prev[M];
    bit exp_step[M];
    bit exp_busy[M];
    bit r, st, drp, d;
    int s;

    always begin
        @(posedge clk);
        cyc++;
        for (int i = 0; i < M; i++) begin
            r = BOTH ? (step_in[i] ^ prev[i]) : (step_in[i] & ~prev[i]);
            prev[i] = step_in[i];
            if (reset) begin
                idle_at[i] = -1;
                hs[i] = -1;
                he[i] = -1;
                mdir[i] = 0;
                pend[i] = 0;
                pdir[i] = 0;
                ovr[i] = 0;
            end else begin
                st = (cyc > idle_at[i]) && (pend[i] || r);
                drp = r && pend[i] && !st;
                if (st) begin
                    d = pend[i] ? pdir[i] : dir_in[i];
                    s = (d != mdir[i]) ? mx1(t_setup) : 0;
                    mdir[i] = d;
                    hs[i] = cyc + s;
                    he[i] = hs[i] + mx1(t_high);
                    idle_at[i] = he[i] + mx1(t_low);
                    pend[i] = pend[i] && r;
                    if (r) pdir[i] = dir_in[i];
                end else if (r && !pend[i]) begin
                    pend[i] = 1;
                    pdir[i] = dir_in[i];
                end
                ovr[i] = drp || (ovr[i] && !ovr_clear);
            end
            exp_step[i] = (cyc >= hs[i]) && (cyc < he[i]);
            exp_busy[i] = (cyc < idle_at[i]) || pend[i];
        end
        #1;
        for (int i = 0; i < M; i++) begin
            check($sformatf("m_step[%0d]", i), 32'(m_step[i]), 32'(exp_step[i]));
            check($sformatf("m_dir[%0d]", i), 32'(m_dir[i]), 32'(mdir[i]));
            check($sformatf("overrun[%0d]", i), 32'(overrun[i]), 32'(ovr[i]));
            check($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(exp_busy[i]));
        end
    end

    task automatic sample();
        @(posedge clk);
        #2;
    endtask

    task automatic settle(input int n);
        step_in = '0;
        repeat (n) @(negedge clk);
    endtask

    int rises;
    int highs;
    bit last;

    task automatic burst(input bit clr_on_drop);
        rises = 0;
        highs = 0;
        last = 0;
        for (int k = 0; k < 60; k++) begin
            step_in[0] = (k < 12) && ((k % 4) < 2);
            ovr_clear = clr_on_drop && (k == 8);
            sample();
            if (k < 12) check("burst_overrun", 32'(overrun[0]), 32'(k >= 8));
            if (m_step[0] && !last) rises++;
            if (m_step[0]) highs++;
            last = m_step[0];
            @(negedge clk);
        end
        ovr_clear = 0;
        check("burst_pulses", rises, 2);
        check("burst_high_clocks", highs, 20);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        check("rst_m_step", 32'(m_step), 0);
        check("rst_m_dir", 32'(m_dir), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_busy", 32'(busy), 0);

        // single step, no dir change
        t_high = 4;
        t_low = 3;
        for (int k = 0; k < 8; k++) begin
            step_in[0] = 1;
            sample();
            check("t1_step", 32'(m_step[0]), 32'(k < 4));
            check("t1_busy", 32'(busy[0]), 32'(k < 7));
            check("t1_dir", 32'(m_dir[0]), 0);
            @(negedge clk);
        end
        settle(3);

        // dir change inserts setup
        t_setup = 5;
        t_high = 2;
        t_low = 2;
        dir_in[0] = 1;
        for (int k = 0; k < 10; k++) begin
            step_in[0] = 1;
            sample();
            check("t2_dir", 32'(m_dir[0]), 1);
            check("t2_step", 32'(m_step[0]), 32'(k == 5 || k == 6));
            check("t2_busy", 32'(busy[0]), 32'(k < 9));
            @(negedge clk);
        end
        settle(3);

        // zero timings, request every 3 clocks
        t_setup = 0;
        t_high = 0;
        t_low = 0;
        for (int k = 0; k < 12; k++) begin
            step_in[0] = ((k % 3) == 0);
            sample();
            check("t4_step", 32'(m_step[0]), 32'((k % 3) == 0));
            check("t4_busy", 32'(busy[0]), 32'((k % 3) != 2));
            check("t4_overrun", 32'(overrun[0]), 0);
            @(negedge clk);
        end
        settle(3);

        // pending slot and overrun
        t_high = 10;
        t_low = 10;
        burst(1'b0);
        ovr_clear = 1;
        sample();
        check("ovr_cleared", 32'(overrun[0]), 0);
        @(negedge clk);
        ovr_clear = 0;
        burst(1'b1);
        check("ovr_set_wins", 32'(overrun[0]), 1);
        settle(3);

        // reset mid-pulse, step_in held high through release
        t_high = 6;
        t_low = 2;
        for (int k = 0; k < 10; k++) begin
            step_in[0] = 1;
            reset = (k == 2 || k == 3);
            sample();
            check("t5_step", 32'(m_step[0]), 32'(k < 2));
            if (k >= 2) begin
                check("t5_busy", 32'(busy), 0);
                check("t5_overrun", 32'(overrun), 0);
            end
            @(negedge clk);
        end
        reset = 0;
        settle(3);

        // two channels at once, motor 1 quiet
        dir_in = '0;
        t_setup = 2;
        t_low = 1;
        for (int run = 0; run < 2; run++) begin
            t_high = (run == 0) ? 8'd3 : 8'd5;
            for (int k = 0; k < 20; k++) begin
                step_in = (k < 10) ? 3'b101 : 3'b000;
                sample();
                d = (k < int'(t_high)) ||
                    (BOTH && k >= 10 && k < 10 + int'(t_high));
                check("t6_step", 32'(m_step), d ? 32'h5 : 32'h0);
                check("t6_m1_dir", 32'(m_dir[1]), 0);
                @(negedge clk);
            end
            settle(4);
        end

        // randomized traffic with quiet drains between timing changes
        for (int seg = 0; seg < 16; seg++) begin
            t_setup = W'($urandom_range(0, 6));
            t_high = W'($urandom_range(0, 6));
            t_low = W'($urandom_range(0, 6));
            for (int c = 0; c < 120; c++) begin
                for (int i = 0; i < M; i++) begin
                    if ($urandom_range(0, 3) == 0) step_in[i] = ~step_in[i];
                    if ($urandom_range(0, 7) == 0) dir_in[i] = ~dir_in[i];
                end
                ovr_clear = ($urandom_range(0, 15) == 0);
                reset = ($urandom_range(0, 199) == 0);
                @(negedge clk);
            end
            reset = 0;
            ovr_clear = 0;
            repeat (80) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
